// File: rtl/if_id_queue.sv
// if_id_queue: first-word-fall-through buffer between the MIPS32 fetch
// and decode stages. It carries {instr, pc4} words under valid/ready
// handshakes on both sides. A branch-taken flush discards every buffered
// word and any word arriving that cycle.
module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [31:0]              fetch_instr,
  input  logic [31:0]              fetch_pc4,
  input  logic                     flush,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each entry holds {instr, pc4}.
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [63:0]   w_head;

  // Occupancy flags and handshake qualifiers. Flush suppresses both sides.
  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_empty = (r_count == '0);
    w_push  = fetch_valid & ~w_full & ~flush;
    w_pop   = ~w_empty & id_ready & ~flush;
  end

  // Fall-through read: the head entry drives decode the cycle it becomes valid.
  always_comb begin
    w_head      = r_mem[r_rd_ptr];
    fetch_ready = ~w_full;
    id_valid    = ~w_empty;
    id_instr    = w_empty ? NOP_WORD : w_head[63:32];
    id_pc4      = w_empty ? 32'h0 : w_head[31:0];
    count       = r_count;
  end

  // Storage write. Contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {fetch_instr, fetch_pc4};
    end
  end

  // Pointer and occupancy update. Flush has priority over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so plain increment wraps DEPTH-1 to 0.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with DEPTH=2 and hand-computed expectations.
module tb_if_id_queue;

  localparam int DEPTH = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   fetch_valid;
  logic                   fetch_ready;
  logic [31:0]            fetch_instr;
  logic [31:0]            fetch_pc4;
  logic                   flush;
  logic                   id_valid;
  logic                   id_ready;
  logic [31:0]            id_instr;
  logic [31:0]            id_pc4;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  if_id_queue #(.DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_instr (fetch_instr),
    .fetch_pc4   (fetch_pc4),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    fetch_valid = v;
    fetch_instr = ins;
    fetch_pc4   = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc4", id_pc4, 32'h0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    // Stream two words straight through.
    id_ready = 1'b1;
    drive(1'b1, 32'h2008_0005, 32'h4);
    step();
    chk("s1_count", 32'(count), 32'd1);
    chk("s1_instr", id_instr, 32'h2008_0005);
    chk("s1_pc4", id_pc4, 32'h4);
    drive(1'b1, 32'h2009_0003, 32'h8);
    step();
    chk("s2_count", 32'(count), 32'd1);
    chk("s2_instr", id_instr, 32'h2009_0003);
    chk("s2_pc4", id_pc4, 32'h8);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("s3_count", 32'(count), 32'd0);
    chk("s3_valid", 32'(id_valid), 32'd0);

    // Fill and backpressure.
    id_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 32'h10);
    step();
    chk("f1_count", 32'(count), 32'd1);
    chk("f1_ready", 32'(fetch_ready), 32'd1);
    drive(1'b1, 32'h2222_2222, 32'h14);
    step();
    chk("f2_count", 32'(count), 32'd2);
    chk("f2_ready", 32'(fetch_ready), 32'd0);
    drive(1'b1, 32'h3333_3333, 32'h18);
    step();
    chk("f3_count", 32'(count), 32'd2);
    chk("f3_instr", id_instr, 32'h1111_1111);
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    step();
    chk("f4_count", 32'(count), 32'd1);
    chk("f4_instr", id_instr, 32'h2222_2222);
    chk("f4_pc4", id_pc4, 32'h14);
    step();
    chk("f5_count", 32'(count), 32'd0);
    chk("f5_valid", 32'(id_valid), 32'd0);
    chk("f5_instr", id_instr, 32'h0);

    // Ten words at steady occupancy one; pointers wrap repeatedly.
    drive(1'b1, 32'h3000_0000, 32'h100);
    step();
    chk("w0_instr", id_instr, 32'h3000_0000);
    for (int k = 1; k < 10; k++) begin
      drive(1'b1, 32'h3000_0000 + 32'(k), 32'h100 + 32'(4 * k));
      step();
      chk("wk_count", 32'(count), 32'd1);
      chk("wk_instr", id_instr, 32'h3000_0000 + 32'(k));
      chk("wk_pc4", id_pc4, 32'h100 + 32'(4 * k));
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("w_end_count", 32'(count), 32'd0);

    // Flush with a full queue and an incoming word.
    id_ready = 1'b0;
    drive(1'b1, 32'h4444_0001, 32'h20);
    step();
    drive(1'b1, 32'h4444_0002, 32'h24);
    step();
    chk("fl_pre_count", 32'(count), 32'd2);
    drive(1'b1, 32'h4444_0003, 32'h28);
    flush = 1'b1;
    id_ready = 1'b1;
    step();
    flush = 1'b0;
    id_ready = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(id_valid), 32'd0);
    chk("fl_ready", 32'(fetch_ready), 32'd1);
    drive(1'b1, 32'hAC0A_0000, 32'h200);
    step();
    chk("fl_next_instr", id_instr, 32'hAC0A_0000);
    chk("fl_next_pc4", id_pc4, 32'h200);
    chk("fl_next_count", 32'(count), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    step();
    chk("fl_drain", 32'(count), 32'd0);

    // Asynchronous reset between edges with two entries held.
    id_ready = 1'b0;
    drive(1'b1, 32'h5555_0001, 32'h30);
    step();
    drive(1'b1, 32'h5555_0002, 32'h34);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_pre_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_instr", id_instr, 32'h0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h5555_5555, 32'h44);
    step();
    chk("ar_resume_count", 32'(count), 32'd1);
    chk("ar_resume_instr", id_instr, 32'h5555_5555);
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    step();

    // Empty reads never pop.
    for (int k = 0; k < 5; k++) begin
      chk("er_count", 32'(count), 32'd0);
      chk("er_instr", id_instr, 32'h0);
      chk("er_pc4", id_pc4, 32'h0);
      chk("er_valid", 32'(id_valid), 32'd0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
